alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 id_valid/id_pc[31:0]/id_rs1_data[31:0]/id_rs2_data[31:0]  in  decode-stage instruction valid, PC and register-file read data.
REQ-003 id_rs1[4:0]/id_rs2[4:0]/id_rd[4:0]/id_imm[31:0]  in  source/destination register numbers and sign-extended immediate.
REQ-004 id_alu_op[3:0]/id_a_sel[1:0]/id_b_sel/id_reg_write/id_mem_read/id_mem_write  in  ALU opcode, A select (0 rs1, 1 pc, 2 zero, 3 zero), B select (0 rs2, 1 imm), and write/load/store flags.
REQ-005 ex_result[31:0]/mem_rd[4:0]/mem_reg_write/mem_result[31:0]/flush  in  ALU Out of the instruction in EX, MEM-stage writeback, and branch-taken flush.
REQ-006 alu_a[31:0]/alu_b[31:0]/alu_op[3:0]  out  registered ALU operands and opcode.
REQ-007 ex_valid/ex_rd[4:0]/ex_reg_write/ex_mem_read/ex_mem_write/ex_store_data[31:0]  out  registered EX-stage control and forwarded rs2 value.
REQ-008 stall  out  1  combinational load-use stall request to fetch/decode.

Function
REQ-009 Per rising edge, priority SHALL be: reset > flush > stall-bubble > capture.
REQ-010 Capture: all outputs except stall SHALL update from decode inputs with one-cycle latency; ex_valid=id_valid.
REQ-011 Forwarded rs1 value SHALL be ex_result if ex_valid&ex_reg_write&~ex_mem_read&ex_rd==id_rs1&id_rs1!=0, else mem_result if mem_reg_write&mem_rd==id_rs1&id_rs1!=0, else id_rs1_data; rs2 identical with id_rs2.
REQ-012 alu_a SHALL be forwarded rs1, id_pc, or 32'h0 per id_a_sel; alu_b SHALL be forwarded rs2 or id_imm per id_b_sel; ex_store_data SHALL always be forwarded rs2.
REQ-013 rs1 "used" SHALL mean id_a_sel==0; rs2 "used" SHALL mean id_b_sel==0 or id_mem_write.
REQ-014 stall SHALL be 1 when id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((rs1 used & ex_rd==id_rs1) | (rs2 used & ex_rd==id_rs2)), and 0 during reset or flush.
REQ-015 Stall-bubble and flush SHALL load a bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, alu_op=4'b0000, alu_a=alu_b=ex_store_data=0, ex_rd=0.
REQ-016 Register x0 SHALL never be a forwarding source or stall cause.
REQ-017 id_valid=0 at capture SHALL produce a bubble identical to REQ-015.
REQ-018 Flush and stall in the same cycle SHALL yield a bubble with stall forced 0.

Reset
REQ-019 When reset is high at a rising edge, every registered output SHALL become 0 (alu_op=4'b0000, ex_valid=0); reset mid-stall SHALL discard the stalled instruction.
REQ-020 stall SHALL read 0 while reset is high.

Configuration
REQ-021 Macro OPERAND_FWD_EN defined: forwarding per REQ-011 and stall per REQ-014.
REQ-022 OPERAND_FWD_EN undefined: operands SHALL come straight from id_rs*_data, and stall SHALL assert for any used-source match (rd!=0) against a valid writing EX instruction or a writing MEM instruction.

Structure
REQ-023 A shared package SHALL hold the 4-bit ALU opcode constants (0000 pass B ... 1100 XOR), A-select and B-select encodings, and the 5-bit register-index type.
REQ-024 One sub-module operand_fwd_mux SHALL implement REQ-011 for a single source, instantiated twice.

Verification
REQ-025 id x1 read 5, EX writes x1 with ex_result=7 (non-load), op 0010, a_sel 0, b_sel 1, imm 3 -> next cycle alu_a=7, alu_b=3, alu_op=0010.
REQ-026 EX and MEM both write x2 (ex_result=9, mem_result=4), id_rs2=2, b_sel 0 -> alu_b=9 (EX priority).
REQ-027 EX load to x3, decode uses x3 as rs1 -> stall=1 for one cycle, bubble (ex_valid=0, alu_op=0) enters EX; following cycle mem_result forwarded into alu_a.
REQ-028 EX writes x0 with ex_result=FFFFFFFF, id_rs1=0, id_rs1_data=0 -> alu_a=0, stall=0.
REQ-029 flush=1 with valid ADD in decode -> next cycle ex_valid=0, ex_reg_write=0, all operands 0.
REQ-030 reset=1 asserted during a load-use stall -> next cycle all outputs 0, stall=0; without OPERAND_FWD_EN, scenario REQ-025 -> stall=1.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared types and encodings for the ALU operand stage: opcodes, operand selects, register index.
package alu_operand_stage_pkg;

   typedef logic [4:0] reg_idx_t;

   localparam logic [3:0] ALU_PASS_B = 4'b0000;
   localparam logic [3:0] ALU_ADD    = 4'b0001;
   localparam logic [3:0] ALU_SUB    = 4'b0010;
   localparam logic [3:0] ALU_SLL    = 4'b0011;
   localparam logic [3:0] ALU_SLT    = 4'b0100;
   localparam logic [3:0] ALU_SLTU   = 4'b0101;
   localparam logic [3:0] ALU_SRL    = 4'b0110;
   localparam logic [3:0] ALU_SRA    = 4'b0111;
   localparam logic [3:0] ALU_AND    = 4'b1000;
   localparam logic [3:0] ALU_OR     = 4'b1001;
   localparam logic [3:0] ALU_LUI    = 4'b1010;
   localparam logic [3:0] ALU_AUIPC  = 4'b1011;
   localparam logic [3:0] ALU_XOR    = 4'b1100;

   typedef enum logic [1:0] {
      A_RS1   = 2'd0,
      A_PC    = 2'd1,
      A_ZERO  = 2'd2,
      A_ZERO2 = 2'd3
   } a_sel_t;

   typedef enum logic {
      B_RS2 = 1'b0,
      B_IMM = 1'b1
   } b_sel_t;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Single-source operand forwarding: EX result (non-load) beats MEM writeback beats register file.
module operand_fwd_mux
   import alu_operand_stage_pkg::*;
(
   input  reg_idx_t    src,
   input  logic [31:0] reg_data,
   input  logic        ex_valid,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  reg_idx_t    ex_rd,
   input  logic [31:0] ex_result,
   input  logic        mem_reg_write,
   input  reg_idx_t    mem_rd,
   input  logic [31:0] mem_result,
   output logic [31:0] fwd_data
);

   logic src_nz;
   logic hit_ex;
   logic hit_mem;

   // A load in EX has only its address on ex_result, so it is never a source here.
   assign src_nz  = (src != 5'd0);
   assign hit_ex  = ex_valid & ex_reg_write & ~ex_mem_read & (ex_rd == src) & src_nz;
   assign hit_mem = mem_reg_write & (mem_rd == src) & src_nz;

   always_comb begin
      fwd_data = reg_data;
      if (hit_ex)
         fwd_data = ex_result;
      else if (hit_mem)
         fwd_data = mem_result;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: operand selection, forwarding and load-use stall, registered into EX.
// OPERAND_FWD_EN enables bypassing; without it sources come from the register file and any hazard stalls.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_imm,
   input  logic [3:0]  id_alu_op,
   input  logic [1:0]  id_a_sel,
   input  logic        id_b_sel,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic [31:0] ex_result,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic [31:0] mem_result,
   input  logic        flush,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic        ex_valid,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic [31:0] ex_store_data,
   output logic        stall
);

   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] a_next;
   logic [31:0] b_next;
   logic        rs1_used;
   logic        rs2_used;
   logic        rs1_hazard;
   logic        rs2_hazard;
   logic        bubble;

   assign rs1_used = (id_a_sel == A_RS1);
   assign rs2_used = (id_b_sel == B_RS2) | id_mem_write;

`ifdef OPERAND_FWD_EN
   operand_fwd_mux u_fwd_rs1 (
      .src          (id_rs1),
      .reg_data     (id_rs1_data),
      .ex_valid     (ex_valid),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .ex_result    (ex_result),
      .mem_reg_write(mem_reg_write),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .fwd_data     (rs1_val)
   );

   operand_fwd_mux u_fwd_rs2 (
      .src          (id_rs2),
      .reg_data     (id_rs2_data),
      .ex_valid     (ex_valid),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .ex_result    (ex_result),
      .mem_reg_write(mem_reg_write),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .fwd_data     (rs2_val)
   );

   // Only a load in EX cannot be bypassed; everything else is covered by the muxes.
   assign rs1_hazard = rs1_used & ex_valid & ex_mem_read & (ex_rd != 5'd0) & (ex_rd == id_rs1);
   assign rs2_hazard = rs2_used & ex_valid & ex_mem_read & (ex_rd != 5'd0) & (ex_rd == id_rs2);
`else
   logic unused_fwd;

   assign rs1_val    = id_rs1_data;
   assign rs2_val    = id_rs2_data;
   assign unused_fwd = ^{ex_result, mem_result};

   // No bypass: wait until neither EX nor MEM still owes a write to a used source.
   assign rs1_hazard = rs1_used & (id_rs1 != 5'd0) &
                       ((ex_valid & ex_reg_write & (ex_rd == id_rs1)) |
                        (mem_reg_write & (mem_rd == id_rs1)));
   assign rs2_hazard = rs2_used & (id_rs2 != 5'd0) &
                       ((ex_valid & ex_reg_write & (ex_rd == id_rs2)) |
                        (mem_reg_write & (mem_rd == id_rs2)));
`endif

   assign stall  = id_valid & (rs1_hazard | rs2_hazard) & ~reset & ~flush;
   assign bubble = reset | flush | stall | ~id_valid;

   always_comb begin
      a_next = 32'h0;
      case (id_a_sel)
         A_RS1:   a_next = rs1_val;
         A_PC:    a_next = id_pc;
         default: a_next = 32'h0;
      endcase
      b_next = (id_b_sel == B_IMM) ? id_imm : rs2_val;
   end

   always_ff @(posedge clk) begin
      if (bubble) begin
         alu_a         <= 32'h0;
         alu_b         <= 32'h0;
         alu_op        <= ALU_PASS_B;
         ex_valid      <= 1'b0;
         ex_rd         <= 5'd0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_store_data <= 32'h0;
      end else begin
         alu_a         <= a_next;
         alu_b         <= b_next;
         alu_op        <= id_alu_op;
         ex_valid      <= 1'b1;
         ex_rd         <= id_rd;
         ex_reg_write  <= id_reg_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
         ex_store_data <= rs2_val;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; expectations follow OPERAND_FWD_EN when it is defined.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_op;
   logic [1:0]  id_a_sel;
   logic        id_b_sel, id_reg_write, id_mem_read, id_mem_write;
   logic [31:0] ex_result, mem_result;
   logic [4:0]  mem_rd;
   logic        mem_reg_write, flush;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [3:0]  alu_op;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
   logic [4:0]  ex_rd;

   int n_cmp = 0;
   int n_bad = 0;

   alu_operand_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
      .id_alu_op(id_alu_op), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .mem_result(mem_result), .flush(flush),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_valid(ex_valid),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      reset = 1'b0; flush = 1'b0;
      id_valid = 1'b0; id_pc = 32'h0; id_rs1_data = 32'h0; id_rs2_data = 32'h0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_imm = 32'h0;
      id_alu_op = 4'd0; id_a_sel = 2'd0; id_b_sel = 1'b0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
      ex_result = 32'h0; mem_result = 32'h0; mem_rd = 5'd0; mem_reg_write = 1'b0;
   endtask

   // Decode a valid instruction; leaves EX/MEM side inputs untouched.
   task automatic drive_id(input logic [4:0] rs1, input logic [31:0] rs1_d,
                           input logic [4:0] rs2, input logic [31:0] rs2_d,
                           input logic [4:0] rd, input logic [31:0] imm,
                           input logic [3:0] op, input logic [1:0] a_sel, input logic b_sel,
                           input logic rw, input logic mr, input logic mw);
      id_valid = 1'b1; id_rs1 = rs1; id_rs1_data = rs1_d; id_rs2 = rs2; id_rs2_data = rs2_d;
      id_rd = rd; id_imm = imm; id_alu_op = op; id_a_sel = a_sel; id_b_sel = b_sel;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   // Drain EX with a bubble, then place a writer of rd (load if mr) into EX.
   task automatic setup_ex_writer(input logic [4:0] rd, input logic mr);
      clear_inputs();
      tick();
      drive_id(5'd0, 32'h0, 5'd0, 32'h0, rd, 32'h100, 4'b0001, 2'd2, 1'b1, 1'b1, mr, 1'b0);
      tick();
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      drive_id(5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 32'h7, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
      n_cmp++; if (alu_op !== 4'b0000) begin n_bad++; $display("FAIL reset_alu_op got %h want 0", alu_op); end
      n_cmp++; if ({alu_a, alu_b, ex_store_data} !== 96'h0) begin n_bad++; $display("FAIL reset_operands got %h %h %h want 0", alu_a, alu_b, ex_store_data); end
      n_cmp++; if ({ex_rd, ex_reg_write, ex_mem_read, ex_mem_write} !== 8'h0) begin n_bad++; $display("FAIL reset_ctrl got %h want 0", {ex_rd, ex_reg_write, ex_mem_read, ex_mem_write}); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
      reset = 1'b0;
   endtask

   task automatic test_fwd_ex();
      setup_ex_writer(5'd1, 1'b0);
      n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || ex_reg_write !== 1'b1 || alu_b !== 32'h100 || alu_a !== 32'h0)
         begin n_bad++; $display("FAIL capture_setup got v=%b rd=%0d rw=%b a=%h b=%h want 1 1 1 0 100", ex_valid, ex_rd, ex_reg_write, alu_a, alu_b); end
      drive_id(5'd1, 32'h5, 5'd0, 32'h0, 5'd4, 32'h3, 4'b0010, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      ex_result = 32'h7;
      settle();
`ifdef OPERAND_FWD_EN
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fwd_ex_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (alu_a !== 32'h7) begin n_bad++; $display("FAIL fwd_ex_alu_a got %h want 7", alu_a); end
      n_cmp++; if (alu_b !== 32'h3 || alu_op !== 4'b0010 || ex_valid !== 1'b1)
         begin n_bad++; $display("FAIL fwd_ex_b_op got b=%h op=%h v=%b want 3 2 1", alu_b, alu_op, ex_valid); end
`else
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_ex_stall got %b want 1", stall); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0 || alu_op !== 4'b0000) begin n_bad++; $display("FAIL nofwd_ex_bubble got v=%b op=%h want 0 0", ex_valid, alu_op); end
      mem_reg_write = 1'b1; mem_rd = 5'd1; mem_result = 32'h7;
      settle();
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_mem_stall got %b want 1", stall); end
      mem_reg_write = 1'b0;
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nofwd_release_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (alu_a !== 32'h5 || alu_b !== 32'h3 || alu_op !== 4'b0010)
         begin n_bad++; $display("FAIL nofwd_raw_operands got a=%h b=%h op=%h want 5 3 2", alu_a, alu_b, alu_op); end
`endif
   endtask

   task automatic test_ex_priority();
      setup_ex_writer(5'd2, 1'b0);
      drive_id(5'd0, 32'h0, 5'd2, 32'h1, 5'd5, 32'h0, 4'b0001, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      ex_result = 32'h9; mem_reg_write = 1'b1; mem_rd = 5'd2; mem_result = 32'h4;
      settle();
`ifdef OPERAND_FWD_EN
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL prio_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (alu_b !== 32'h9) begin n_bad++; $display("FAIL prio_alu_b got %h want 9", alu_b); end
      n_cmp++; if (ex_store_data !== 32'h9) begin n_bad++; $display("FAIL prio_store got %h want 9", ex_store_data); end
`else
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_prio_stall got %b want 1", stall); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL nofwd_prio_bubble got %b want 0", ex_valid); end
`endif
   endtask

   task automatic test_load_use();
      setup_ex_writer(5'd3, 1'b1);
      drive_id(5'd3, 32'h11, 5'd0, 32'h0, 5'd5, 32'h1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      ex_result = 32'h100;
      settle();
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL load_use_stall got %b want 1", stall); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0 || alu_op !== 4'b0000 || alu_a !== 32'h0 || ex_reg_write !== 1'b0)
         begin n_bad++; $display("FAIL load_use_bubble got v=%b op=%h a=%h rw=%b want 0 0 0 0", ex_valid, alu_op, alu_a, ex_reg_write); end
      mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'hABCD;
      settle();
`ifdef OPERAND_FWD_EN
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL load_use_release got %b want 0", stall); end
      tick();
      n_cmp++; if (alu_a !== 32'hABCD || alu_b !== 32'h1 || ex_valid !== 1'b1)
         begin n_bad++; $display("FAIL load_use_mem_fwd got a=%h b=%h v=%b want abcd 1 1", alu_a, alu_b, ex_valid); end
`else
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_load_mem_stall got %b want 1", stall); end
      tick();
`endif
   endtask

   task automatic test_x0();
      setup_ex_writer(5'd0, 1'b0);
      drive_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 32'h5, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      ex_result = 32'hFFFF_FFFF; mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFF_FFFF;
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h5 || ex_valid !== 1'b1)
         begin n_bad++; $display("FAIL x0_alu_a got a=%h b=%h v=%b want 0 5 1", alu_a, alu_b, ex_valid); end
   endtask

   task automatic test_flush();
      clear_inputs();
      tick();
      drive_id(5'd8, 32'h12, 5'd9, 32'h34, 5'd7, 32'h0, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_plain_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || alu_op !== 4'b0000)
         begin n_bad++; $display("FAIL flush_ctrl got v=%b rw=%b rd=%0d op=%h want 0 0 0 0", ex_valid, ex_reg_write, ex_rd, alu_op); end
      n_cmp++; if ({alu_a, alu_b, ex_store_data} !== 96'h0) begin n_bad++; $display("FAIL flush_operands got %h %h %h want 0", alu_a, alu_b, ex_store_data); end
      setup_ex_writer(5'd6, 1'b1);
      drive_id(5'd6, 32'h12, 5'd0, 32'h0, 5'd7, 32'h0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_pre_stall got %b want 1", stall); end
      flush = 1'b1;
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall_forced got %b want 0", stall); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin n_bad++; $display("FAIL flush_stall_bubble got v=%b mr=%b want 0 0", ex_valid, ex_mem_read); end
      flush = 1'b0;
   endtask

   task automatic test_id_invalid();
      clear_inputs();
      drive_id(5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 32'h7, 4'b1100, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1);
      id_valid = 1'b0; id_pc = 32'h80;
      tick();
      n_cmp++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_mem_write !== 1'b0 || alu_a !== 32'h0 || ex_store_data !== 32'h0)
         begin n_bad++; $display("FAIL invalid_bubble got v=%b rd=%0d mw=%b a=%h sd=%h want 0", ex_valid, ex_rd, ex_mem_write, alu_a, ex_store_data); end
   endtask

   task automatic test_reset_mid_stall();
      setup_ex_writer(5'd3, 1'b1);
      drive_id(5'd3, 32'h11, 5'd0, 32'h0, 5'd5, 32'h1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall_pre got %b want 1", stall); end
      reset = 1'b1;
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall_forced got %b want 0", stall); end
      tick();
      n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0 || alu_op !== 4'b0000 || alu_b !== 32'h0)
         begin n_bad++; $display("FAIL rst_mid_stall got v=%b mr=%b rd=%0d op=%h b=%h want 0", ex_valid, ex_mem_read, ex_rd, alu_op, alu_b); end
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      clear_inputs();
      tick();
      drive_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 32'h4, 4'b0001, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      id_pc = 32'h40;
      tick();
      n_cmp++; if (alu_a !== 32'h40 || alu_b !== 32'h4 || ex_rd !== 5'd10)
         begin n_bad++; $display("FAIL b2b_first got a=%h b=%h rd=%0d want 40 4 10", alu_a, alu_b, ex_rd); end
      drive_id(5'd0, 32'h0, 5'd11, 32'h55, 5'd0, 32'h8, 4'b0001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall got %b want 0", stall); end
      tick();
      n_cmp++; if (ex_store_data !== 32'h55 || ex_mem_write !== 1'b1 || alu_a !== 32'h0 || alu_b !== 32'h8 || ex_reg_write !== 1'b0)
         begin n_bad++; $display("FAIL b2b_store got sd=%h mw=%b a=%h b=%h rw=%b want 55 1 0 8 0", ex_store_data, ex_mem_write, alu_a, alu_b, ex_reg_write); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fwd_ex();
      test_ex_priority();
      test_load_use();
      test_x0();
      test_flush();
      test_id_invalid();
      test_reset_mid_stall();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
